// File: rtl/seq_cla_addsub.sv
// Multi-cycle carry-lookahead adder/subtractor: W-bit operands are processed CHUNK bits
// per cycle through one lookahead slice, with a registered carry between beats.
module seq_cla_addsub #(
    parameter int W     = 64,
    parameter int CHUNK = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic         sat,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovfl,
    output logic         zero
);

    localparam int BEATS = W / CHUNK;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((CHUNK <= 0) || ((W % CHUNK) != 0)) begin : g_bad_param
        $error("seq_cla_addsub: W must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    acc;
    logic            carry;
    logic            sat_r;
    logic [BW-1:0]   beat;

    int              base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]  c;
    logic [CHUNK-1:0] s_chunk;
    logic            t;
    logic            pp;
    logic [W-1:0]    raw;
    logic [W-1:0]    final_sum;
    logic            raw_ovfl;
    logic            last_beat;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        base    = int'(beat) * CHUNK;
        a_chunk = a_r[base +: CHUNK];
        b_chunk = b_r[base +: CHUNK];
        g       = a_chunk & b_chunk;
        p       = a_chunk ^ b_chunk;
        t       = 1'b0;
        pp      = 1'b0;
        c       = '0;
        c[0]    = carry;
        // Flat sum-of-products lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i:0]carry.
        for (int i = 0; i < CHUNK; i++) begin
            t  = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = t | (pp & carry);
        end
        s_chunk = p ^ c[CHUNK-1:0];

        raw               = acc;
        raw[base +: CHUNK] = s_chunk;
        // Only meaningful on the last beat, where c[CHUNK-1] is the carry into bit W-1.
        raw_ovfl  = c[CHUNK] ^ c[CHUNK-1];
        final_sum = raw;
        if (sat_r && raw_ovfl) begin
            final_sum = a_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        last_beat = (beat == BW'(BEATS - 1));
    end

    // NOTE: sequential state uses non-blocking assignments only; later assignments win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            sat_r <= 1'b0;
            beat  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovfl  <= 1'b0;
            zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    acc[base +: CHUNK] <= s_chunk;
                    carry              <= c[CHUNK];
                    beat               <= beat + 1'b1;
                    if (last_beat) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        beat  <= '0;
                        sum   <= final_sum;
                        c_out <= c[CHUNK];
                        ovfl  <= raw_ovfl;
                        zero  <= (final_sum == '0);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            // Accept a new operation from IDLE or DONE (back-to-back); ignored during RUN.
            if (start && (state != RUN)) begin
                state <= RUN;
                busy  <= 1'b1;
                a_r   <= a;
                b_r   <= b ^ {W{sub}};
                carry <= sub ? 1'b1 : c_in;
                sat_r <= sat;
                beat  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seq_cla_addsub.sv
// Scoreboard bench for seq_cla_addsub: a W=64/CHUNK=16 instance and a W=64/CHUNK=64 instance.
module tb_seq_cla_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        start0, sub0, sat0, c_in0;
    logic [63:0] a0, b0;
    logic        busy0, done0, c_out0, ovfl0, zero0;
    logic [63:0] sum0;

    logic        start1, sub1, sat1, c_in1;
    logic [63:0] a1, b1;
    logic        busy1, done1, c_out1, ovfl1, zero1;
    logic [63:0] sum1;

    seq_cla_addsub #(.W(64), .CHUNK(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub0), .sat(sat0),
        .a(a0), .b(b0), .c_in(c_in0), .busy(busy0), .done(done0),
        .sum(sum0), .c_out(c_out0), .ovfl(ovfl0), .zero(zero0)
    );

    seq_cla_addsub #(.W(64), .CHUNK(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .sat(sat1),
        .a(a1), .b(b1), .c_in(c_in1), .busy(busy1), .done(done1),
        .sum(sum1), .c_out(c_out1), .ovfl(ovfl1), .zero(zero1)
    );

    typedef struct {
        logic [63:0] sum;
        logic        c_out;
        logic        ovfl;
        logic        zero;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   start_edge = 0;
    logic prev_done0 = 1'b0;
    logic prev_done1 = 1'b0;
    exp_t e0, e1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: 65-bit addition; overflow from operand/result sign agreement.
    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic s, input logic st);
        exp_t        e;
        logic [63:0] bb;
        logic [64:0] full;
        bb      = s ? ~b : b;
        full    = {1'b0, a} + {1'b0, bb} + {64'd0, (s ? 1'b1 : ci)};
        e.c_out = full[64];
        e.ovfl  = (a[63] == bb[63]) && (full[63] != a[63]);
        e.sum   = full[63:0];
        if (st && e.ovfl) e.sum = a[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
        e.zero  = (e.sum == 64'd0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done0) begin
            check("done0_pulse", {63'd0, prev_done0}, 64'd0);
            if (q0.size() == 0) begin
                check("done0_unexpected", {63'd0, done0}, 64'd0);
            end else begin
                e0 = q0.pop_front();
                check("sum0", sum0, e0.sum);
                check("c_out0", {63'd0, c_out0}, {63'd0, e0.c_out});
                check("ovfl0", {63'd0, ovfl0}, {63'd0, e0.ovfl});
                check("zero0", {63'd0, zero0}, {63'd0, e0.zero});
            end
        end
        prev_done0 = done0;
    end

    always @(negedge clk) begin
        if (done1) begin
            check("done1_pulse", {63'd0, prev_done1}, 64'd0);
            if (q1.size() == 0) begin
                check("done1_unexpected", {63'd0, done1}, 64'd0);
            end else begin
                e1 = q1.pop_front();
                check("sum1", sum1, e1.sum);
                check("c_out1", {63'd0, c_out1}, {63'd0, e1.c_out});
                check("ovfl1", {63'd0, ovfl1}, {63'd0, e1.ovfl});
                check("zero1", {63'd0, zero1}, {63'd0, e1.zero});
            end
        end
        prev_done1 = done1;
    end

    // Called at a negedge; start is sampled on the following posedge.
    task automatic start_op(input bit sel, input logic [63:0] a, input logic [63:0] b,
                            input logic ci, input logic s, input logic st, input bit push);
        if (!sel) begin
            a0 = a; b0 = b; c_in0 = ci; sub0 = s; sat0 = st; start0 = 1'b1;
            if (push) q0.push_back(model(a, b, ci, s, st));
        end else begin
            a1 = a; b1 = b; c_in1 = ci; sub1 = s; sat1 = st; start1 = 1'b1;
            if (push) q1.push_back(model(a, b, ci, s, st));
        end
        @(negedge clk);
        start0     = 1'b0;
        start1     = 1'b0;
        start_edge = cyc;
    endtask

    // Returns at the negedge where done is seen; optionally checks sum holds meanwhile.
    task automatic wait_done(input bit sel, input int lat, input bit hold, input logic [63:0] hv);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 20) begin
            if (sel ? done1 : done0) begin
                seen = 1'b1;
                check("latency", 64'(cyc - start_edge), 64'(lat));
                check("busy_at_done", {63'd0, (sel ? busy1 : busy0)}, 64'd0);
            end else begin
                check("busy_in_run", {63'd0, (sel ? busy1 : busy0)}, 64'd1);
                if (hold) check("sum_hold", sel ? sum1 : sum0, hv);
                n++;
                @(negedge clk);
            end
        end
        if (!seen) check("done_timeout", {63'd0, (sel ? done1 : done0)}, 64'd1);
    endtask

    logic [63:0] va [6];
    logic [63:0] vb [6];
    logic        vs [6];
    logic        vt [6];
    logic [63:0] ra, rb;
    exp_t        first;

    initial begin
        rst_n = 1'b0;
        {start0, sub0, sat0, c_in0, start1, sub1, sat1, c_in1} = '0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #1;
        check("rst_busy", {63'd0, busy0}, 64'd0);
        check("rst_done", {63'd0, done0}, 64'd0);
        check("rst_sum", sum0, 64'd0);
        check("rst_c_out", {63'd0, c_out0}, 64'd0);
        check("rst_ovfl", {63'd0, ovfl0}, 64'd0);
        check("rst_zero", {63'd0, zero0}, 64'd0);
        check("rst_sum1", sum1, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h1;                   vs[0] = 0; vt[0] = 0;
        va[1] = 64'd5;                   vb[1] = 64'd7;                   vs[1] = 1; vt[1] = 0;
        va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h1;                   vs[2] = 0; vt[2] = 0;
        va[3] = 64'h7FFF_FFFF_FFFF_FFFF; vb[3] = 64'h1;                   vs[3] = 0; vt[3] = 1;
        va[4] = 64'h8000_0000_0000_0000; vb[4] = 64'hFFFF_FFFF_FFFF_FFFF; vs[4] = 0; vt[4] = 1;
        va[5] = 64'h0000_FFFF_0000_FFFF; vb[5] = 64'h0001_0000_FFFF_0000; vs[5] = 0; vt[5] = 0;
        for (int i = 0; i < 6; i++) begin
            start_op(0, va[i], vb[i], (i == 5), vs[i], vt[i], 1);
            wait_done(0, 4, 0, 64'd0);
            @(negedge clk);
        end

        // Second start during RUN is ignored; operand inputs change after acceptance.
        start_op(0, 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b0, 1);
        a0 = 64'hAAAA_AAAA_AAAA_AAAA; b0 = 64'h5555; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 4, 0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_extra_done", {63'd0, done0}, 64'd0);
        end

        // Back-to-back: start in the DONE cycle.
        first = model(64'h0F0F_0F0F_F0F0_F0F0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b0);
        start_op(0, 64'h0F0F_0F0F_F0F0_F0F0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 1'b0, 1);
        wait_done(0, 4, 0, 64'd0);
        start_op(0, 64'd100, 64'd40, 1'b0, 1'b1, 1'b0, 1);
        wait_done(0, 4, 1, first.sum);

        // Reset pulse during RUN beat 2 aborts the operation.
        @(negedge clk);
        start_op(0, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy", {63'd0, busy0}, 64'd0);
        check("arst_done", {63'd0, done0}, 64'd0);
        check("arst_sum", sum0, 64'd0);
        check("arst_c_out", {63'd0, c_out0}, 64'd0);
        check("arst_ovfl", {63'd0, ovfl0}, 64'd0);
        check("arst_zero", {63'd0, zero0}, 64'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("aborted_no_done", {63'd0, done0}, 64'd0);
        end
        start_op(0, 64'h1234, 64'h1, 1'b0, 1'b0, 1'b0, 1);
        wait_done(0, 4, 0, 64'd0);
        check("post_reset_sum", sum0, 64'h1235);

        // Single-beat instance: random vectors, issued back-to-back from DONE.
        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i % 6 == 1) ra = 64'h7FFF_FFFF_FFFF_FFFF;
            if (i % 6 == 2) rb = ra;
            start_op(1, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1);
            wait_done(1, 1, 0, 64'd0);
        end

        repeat (3) @(negedge clk);
        check("q0_empty", 64'(q0.size()), 64'd0);
        check("q1_empty", 64'(q1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
